idex_hazard_reg: RTL
====================

Name: idex_hazard_reg

Overview:
- ID/EX pipeline register plus hazard detector, sitting directly upstream of the EX forwarding unit (bypass_ex).
- Latches decoded register specifiers and control bits from ID into EX. These registered outputs are the rr1_ex/rr2_ex/write-enable inputs bypass_ex consumes.
- Detects hazards forwarding cannot cover: load-use, and a busy multicycle mult/div unit.
- On a hazard it freezes PC/IF-ID and injects a bubble. Also applies branch flushes from EX.

Parameters:
- REG_W, 5, register specifier width.
- MD_LATENCY, 32, cycles a mult/div occupies its unit (≥2).
- CNT_W, $clog2(MD_LATENCY)+1, busy counter width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  ID source 1.
- id_rt  in  REG_W  ID source 2.
- id_wr  in  REG_W  ID destination.
- id_regW  in  1  ID instruction writes the register file.
- id_memRead  in  1  ID instruction is a load.
- id_isMD  in  1  ID instruction is mult/div.
- flush_ex  in  1  taken branch/jump resolved in EX; kill ID.
- rr1_ex  out  REG_W  registered source 1 (to bypass_ex).
- rr2_ex  out  REG_W  registered source 2.
- wr_ex  out  REG_W  registered destination.
- regW_ex  out  1  registered write enable (gated by valid).
- memRead_ex  out  1  registered load flag.
- isMD_ex  out  1  registered mult/div flag.
- valid_ex  out  1  EX holds a real instruction.
- stall_id  out  1  combinational: hold PC and IF/ID this cycle.
- md_busy  out  1  mult/div unit occupied.

Behaviour:
- Reset (async, reset_n=0): all registered outputs 0, busy counter 0, md_busy=0. stall_id=0 while in reset.
- Dependency terms (combinational):
  - uses_rs = id_rs≠0; uses_rt = id_rt≠0 (r0 never hazards).
  - load_use = id_valid & valid_ex & memRead_ex & wr_ex≠0 & ((uses_rs & id_rs==wr_ex) | (uses_rt & id_rt==wr_ex)).
  - md_hazard = id_valid & md_busy & (id_isMD | (uses_rs & id_rs==md_wr) | (uses_rt & id_rt==md_wr)). md_wr is the internally held destination of the in-flight mult/div.
- stall_id = ~flush_ex & (load_use | md_hazard). Flush always wins over a stall.
- Each rising edge:
  - If flush_ex or stall_id: inject a bubble. valid_ex, regW_ex, memRead_ex and isMD_ex go to 0. Specifier fields go to 0 so bypass_ex sees r0.
  - Otherwise: capture ID fields. valid_ex ← id_valid; regW_ex ← id_regW & id_valid; same gating for memRead_ex and isMD_ex.
- Busy counter, evaluated each edge:
  - An accepted ID instruction with id_isMD (not stalled, not flushed) loads the counter with MD_LATENCY and captures md_wr ← id_wr.
  - Otherwise, if the counter is nonzero, it decrements.
  - md_busy = counter≠0. It asserts the cycle after the mult/div enters EX and holds for MD_LATENCY cycles.
  - A new mult/div can never load while busy (md_hazard blocks it). There is no reload race.
- Flush does not cancel an in-flight mult/div; it kills only the ID instruction.
- Load-use stall lasts exactly one cycle: the next cycle EX holds the bubble, so load_use drops.
- Simultaneous load_use and md_hazard: a single stall. It persists while md_hazard holds.
- Reset asserted mid mult/div clears the counter immediately.
- Latency: ID→EX is one cycle; hazard outputs are same-cycle combinational.

Optional Feature:
- HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each cycle with stall_id=1; flush_cnt on each cycle with flush_ex=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - REG_W and the R0 constant;
  - a typedef for the ID/EX control bundle {regW, memRead, isMD, valid};
  - MD_LATENCY default.
- One natural sub-module: md_busy_counter, containing the counter, md_wr capture and md_busy.

Test Plan:
- Reset: reset_n=0 mid-stream, then released → all EX outputs 0, md_busy=0, stall_id=0.
- Load-use: EX holds `lw` with wr_ex=5 and memRead_ex=1; ID has id_rs=5, id_valid=1.
  - Expect stall_id=1 for one cycle and a bubble in EX (valid_ex=0, regW_ex=0).
  - The next edge captures rs=5 normally.
- Load to r0: wr_ex=0, id_rs=0 → no stall.
- Mult/div: accept id_isMD=1, id_wr=7 with MD_LATENCY=4.
  - Expect md_busy high for 4 cycles.
  - ID reading rt=7 stalls through all 4 busy cycles, then proceeds.
  - ID reading rt=8 does not stall.
- Flush beats stall: load_use condition and flush_ex=1 together → stall_id=0, bubble injected, counter unaffected.
- HAZARD_STATS_EN: 3 stall cycles plus 2 flush cycles → stall_cnt=3, flush_cnt=2. Preloading a near-max value confirms saturation at 16'hFFFF.

Source files
------------

// File: rtl/idex_hazard_reg_pkg.sv
// Shared types and defaults for the ID/EX register and hazard detector.
// Holds the default register specifier width, the r0 constant, the default
// mult/div occupancy and the ID/EX control bundle type.
package idex_hazard_reg_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] R0 = '0;
  localparam int MD_LATENCY = 32;

  // Control bits carried from ID into EX; all clear means a bubble.
  typedef struct packed {
    logic regW;
    logic memRead;
    logic isMD;
    logic valid;
  } idexCtrl_t;

endpackage

// File: rtl/idex_hazard_reg_if.sv
// ID-side instruction fields in, EX-side registered fields and hazard status out.
// master drives the ID fields and the flush; slave is the ID/EX register itself.
// Widths follow REG_W, which must match the attached idex_hazard_reg instance.
interface idex_hazard_reg_if #(
  parameter int REG_W = idex_hazard_reg_pkg::REG_W
);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_wr;
  logic             id_regW;
  logic             id_memRead;
  logic             id_isMD;
  logic             flush_ex;

  logic [REG_W-1:0] rr1_ex;
  logic [REG_W-1:0] rr2_ex;
  logic [REG_W-1:0] wr_ex;
  logic             regW_ex;
  logic             memRead_ex;
  logic             isMD_ex;
  logic             valid_ex;
  logic             stall_id;
  logic             md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_wr, id_regW, id_memRead, id_isMD, flush_ex,
    input  rr1_ex, rr2_ex, wr_ex, regW_ex, memRead_ex, isMD_ex, valid_ex,
    input  stall_id, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_wr, id_regW, id_memRead, id_isMD, flush_ex,
    output rr1_ex, rr2_ex, wr_ex, regW_ex, memRead_ex, isMD_ex, valid_ex,
    output stall_id, md_busy
  );

endinterface

// File: rtl/idex_hazard_reg_md_busy_counter.sv
// Tracks occupancy of the multicycle mult/div unit and its destination register.
// Latency: busy asserts on the edge that accepts the mult/div, holds MD_LATENCY cycles.
// Backpressure: none here; the caller never loads while busy (md hazard stalls ID).
module idex_hazard_reg_md_busy_counter #(
  parameter int REG_W      = idex_hazard_reg_pkg::REG_W,
  parameter int MD_LATENCY = idex_hazard_reg_pkg::MD_LATENCY,
  parameter int CNT_W      = $clog2(MD_LATENCY) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             mdLoad,
  input  logic [REG_W-1:0] mdWrIn,
  output logic             mdBusy,
  output logic [REG_W-1:0] mdWr
);

  logic [CNT_W-1:0] cnt;

  // Load on an accepted mult/div, otherwise count down to idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      mdWr <= '0;
    end else if (mdLoad) begin
      cnt  <= CNT_W'(MD_LATENCY);
      mdWr <= mdWrIn;
    end else if (cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign mdBusy = (cnt != '0);

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use and busy mult/div hazard detection.
// Latency: ID->EX one cycle; stall_id is same-cycle combinational.
// Backpressure: stall_id freezes PC/IF-ID and a bubble enters EX; flush_ex overrides stall.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module idex_hazard_reg #(
  parameter int REG_W      = idex_hazard_reg_pkg::REG_W,
  parameter int MD_LATENCY = idex_hazard_reg_pkg::MD_LATENCY,
  parameter int CNT_W      = $clog2(MD_LATENCY) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  idex_hazard_reg_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  import idex_hazard_reg_pkg::*;

  logic [REG_W-1:0] rr1Q, rr2Q, wrQ;
  idexCtrl_t        ctrlQ;
  logic             mdBusy;
  logic [REG_W-1:0] mdWr;
  logic             usesRs, usesRt, loadUse, mdHazard, stall, mdLoad;

  // r0 never carries a dependency, so specifier 0 is excluded from every match.
  assign usesRs = (bus.id_rs != REG_W'(R0));
  assign usesRt = (bus.id_rt != REG_W'(R0));

  assign loadUse = bus.id_valid & ctrlQ.valid & ctrlQ.memRead & (wrQ != REG_W'(R0)) &
                   ((usesRs & (bus.id_rs == wrQ)) | (usesRt & (bus.id_rt == wrQ)));

  // Any new mult/div, or any reader of the in-flight mult/div result, waits.
  assign mdHazard = bus.id_valid & mdBusy &
                    (bus.id_isMD | (usesRs & (bus.id_rs == mdWr)) | (usesRt & (bus.id_rt == mdWr)));

  assign stall  = ~bus.flush_ex & (loadUse | mdHazard);
  assign mdLoad = ~bus.flush_ex & ~stall & bus.id_valid & bus.id_isMD;

  // Pipeline register: bubble (all zero, specifiers read as r0) on flush or stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr1Q  <= '0;
      rr2Q  <= '0;
      wrQ   <= '0;
      ctrlQ <= '0;
    end else if (bus.flush_ex | stall) begin
      rr1Q  <= '0;
      rr2Q  <= '0;
      wrQ   <= '0;
      ctrlQ <= '0;
    end else begin
      rr1Q          <= bus.id_rs;
      rr2Q          <= bus.id_rt;
      wrQ           <= bus.id_wr;
      ctrlQ.valid   <= bus.id_valid;
      ctrlQ.regW    <= bus.id_regW & bus.id_valid;
      ctrlQ.memRead <= bus.id_memRead & bus.id_valid;
      ctrlQ.isMD    <= bus.id_isMD & bus.id_valid;
    end
  end

  idex_hazard_reg_md_busy_counter #(
    .REG_W      (REG_W),
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_mdBusy (
    .clock   (clock),
    .reset_n (reset_n),
    .mdLoad  (mdLoad),
    .mdWrIn  (bus.id_wr),
    .mdBusy  (mdBusy),
    .mdWr    (mdWr)
  );

  assign bus.rr1_ex     = rr1Q;
  assign bus.rr2_ex     = rr2Q;
  assign bus.wr_ex      = wrQ;
  assign bus.regW_ex    = ctrlQ.regW;
  assign bus.memRead_ex = ctrlQ.memRead;
  assign bus.isMD_ex    = ctrlQ.isMD;
  assign bus.valid_ex   = ctrlQ.valid;
  assign bus.stall_id   = stall;
  assign bus.md_busy    = mdBusy;

`ifdef HAZARD_STATS_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (bus.flush_ex && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
